// File: rtl/riscv_pkg.sv
// Shared RV32 decode definitions: opcodes, immediate formats, ALU operation
// codes and the ID/EX control bundle.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J,
        IMM_U
    } imm_src_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       result_src;
        logic       branch;
        logic [2:0] alu_ctrl;
    } idex_ctrl_t;

    // funct3 selects the operation; sub is instr[30] for R-type, 0 for OP-IMM.
    function automatic logic [2:0] alu_decode(input logic [2:0] funct3, input logic sub);
        logic [2:0] op;
        case (funct3)
            3'b000:  op = sub ? ALU_SUB : ALU_ADD;
            3'b010:  op = ALU_SLT;
            3'b100:  op = ALU_XOR;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/hazard_detect_lu.sv
// Load-use hazard detector: compares the load sitting in the ID/EX slot with
// the source registers of the instruction currently in ID.
module hazard_detect_lu #(
    parameter int RAW = 5
) (
    input  logic           valid_e,
    input  logic           result_src_e,
    input  logic           reg_write_e,
    input  logic [RAW-1:0] rd_e,
    input  logic           valid_d,
    input  logic [RAW-1:0] rs1_d,
    input  logic [RAW-1:0] rs2_d,
    input  logic           uses_rs1_d,
    input  logic           uses_rs2_d,
    input  logic           hold_e,
    output logic           lu,
    output logic           stall_d
);

    logic load_in_e;
    logic src_match;

    assign load_in_e = valid_e && result_src_e && reg_write_e && (rd_e != '0);
    assign src_match = ((rd_e == rs1_d) && uses_rs1_d) || ((rd_e == rs2_d) && uses_rs2_d);

    assign lu      = load_in_e && valid_d && src_match;
    assign stall_d = lu || hold_e;

endmodule

// File: rtl/decode_stage_hz.sv
// RV32 decode stage with register file, immediate generation, load-use stall
// and the ID/EX register. Define DECODE_WB_BYPASS_EN for WB-to-ID write-through.
module decode_stage_hz
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int RAW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_d,
    input  logic [31:0]     instr_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pc_plus4_d,
    input  logic [XLEN-1:0] result_w,
    input  logic            reg_write_w,
    input  logic [RAW-1:0]  rd_w,
    input  logic            flush_e,
    input  logic            hold_e,
    output logic            stall_d,
    output logic            valid_e,
    output logic            reg_write_e,
    output logic            alu_src_e,
    output logic            mem_write_e,
    output logic            result_src_e,
    output logic            branch_e,
    output logic [2:0]      alu_ctrl_e,
    output logic [XLEN-1:0] rd1_e,
    output logic [XLEN-1:0] rd2_e,
    output logic [XLEN-1:0] imm_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] pc_plus4_e,
    output logic [RAW-1:0]  rs1_e,
    output logic [RAW-1:0]  rs2_e,
    output logic [RAW-1:0]  rd_e,
    output logic [RAW-1:0]  rs1_d,
    output logic [RAW-1:0]  rs2_d
);

    localparam int             IW       = $clog2(NREG);
    localparam logic [RAW:0]   NREG_LIM = (RAW+1)'(NREG);

    typedef struct packed {
        logic            valid;
        idex_ctrl_t      ctrl;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [RAW-1:0]  rs1;
        logic [RAW-1:0]  rs2;
        logic [RAW-1:0]  rd;
    } idex_t;

    function automatic logic in_range(input logic [RAW-1:0] a);
        return {1'b0, a} < NREG_LIM;
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [RAW-1:0]  rd_d;
    idex_ctrl_t      ctrl_d;
    imm_src_t        imm_src;
    logic            uses_rs1;
    logic            uses_rs2;
    logic [XLEN-1:0] imm_d;
    logic [XLEN-1:0] rd1_d;
    logic [XLEN-1:0] rd2_d;
    logic            lu;
    idex_t           idex_d;
    idex_t           idex_q;

    assign opcode = instr_d[6:0];
    assign funct3 = instr_d[14:12];
    assign rd_d   = RAW'(instr_d[11:7]);
    assign rs1_d  = RAW'(instr_d[19:15]);
    assign rs2_d  = RAW'(instr_d[24:20]);

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ctrl_d   = '0;
        imm_src  = IMM_NONE;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_LOAD: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.result_src = 1'b1;
                ctrl_d.alu_ctrl   = ALU_ADD;
                imm_src           = IMM_I;
            end
            OP_STORE: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.alu_ctrl  = ALU_ADD;
                imm_src          = IMM_S;
                uses_rs2         = 1'b1;
            end
            OP_R: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_ctrl  = alu_decode(funct3, instr_d[30]);
                uses_rs2         = 1'b1;
            end
            OP_I: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.alu_ctrl  = alu_decode(funct3, 1'b0);
                imm_src          = IMM_I;
            end
            OP_BRANCH: begin
                ctrl_d.branch   = 1'b1;
                ctrl_d.alu_ctrl = ALU_SUB;
                imm_src         = IMM_B;
                uses_rs2        = 1'b1;
            end
            OP_JAL: begin
                ctrl_d.reg_write = 1'b1;
                imm_src          = IMM_J;
                uses_rs1         = 1'b0;
            end
            OP_LUI, OP_AUIPC: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.alu_ctrl  = ALU_ADD;
                imm_src          = IMM_U;
                uses_rs1         = 1'b0;
            end
            default: ;
        endcase
        if (!valid_d) begin
            ctrl_d = '0;
        end
    end

    // Every format keeps its sign in instr[31], so the upper fill is shared.
    always_comb begin
        imm_d = {XLEN{instr_d[31]}};
        case (imm_src)
            IMM_I:   imm_d[11:0] = instr_d[31:20];
            IMM_S:   imm_d[11:0] = {instr_d[31:25], instr_d[11:7]};
            IMM_B:   imm_d[12:0] = {instr_d[31], instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
            IMM_J:   imm_d[20:0] = {instr_d[31], instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};
            IMM_U:   imm_d[31:0] = {instr_d[31:12], 12'b0};
            default: imm_d = '0;
        endcase
    end

    logic [XLEN-1:0] rf [NREG];
    logic            wr_ok;
    logic            rs1_ok;
    logic            rs2_ok;

    assign wr_ok  = reg_write_w && (rd_w != '0) && in_range(rd_w);
    assign rs1_ok = (rs1_d != '0) && in_range(rs1_d);
    assign rs2_ok = (rs2_d != '0) && in_range(rs2_d);

    // NOTE: the register file is reset explicitly; software may read a register before writing it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_ok) begin
            rf[rd_w[IW-1:0]] <= result_w;
        end
    end

    always_comb begin
        rd1_d = rs1_ok ? rf[rs1_d[IW-1:0]] : '0;
        rd2_d = rs2_ok ? rf[rs2_d[IW-1:0]] : '0;
`ifdef DECODE_WB_BYPASS_EN
        if (wr_ok && (rd_w == rs1_d)) rd1_d = result_w;
        if (wr_ok && (rd_w == rs2_d)) rd2_d = result_w;
`endif
    end

    hazard_detect_lu #(
        .RAW(RAW)
    ) u_hazard (
        .valid_e     (idex_q.valid),
        .result_src_e(idex_q.ctrl.result_src),
        .reg_write_e (idex_q.ctrl.reg_write),
        .rd_e        (idex_q.rd),
        .valid_d     (valid_d),
        .rs1_d       (rs1_d),
        .rs2_d       (rs2_d),
        .uses_rs1_d  (uses_rs1),
        .uses_rs2_d  (uses_rs2),
        .hold_e      (hold_e),
        .lu          (lu),
        .stall_d     (stall_d)
    );

    always_comb begin
        idex_d.valid    = valid_d;
        idex_d.ctrl     = ctrl_d;
        idex_d.rd1      = rd1_d;
        idex_d.rd2      = rd2_d;
        idex_d.imm      = imm_d;
        idex_d.pc       = pc_d;
        idex_d.pc_plus4 = pc_plus4_d;
        idex_d.rs1      = rs1_d;
        idex_d.rs2      = rs2_d;
        idex_d.rd       = rd_d;
    end

    // Flush outranks hold; a load-use bubble only forms when EX is accepting.
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idex_q <= '0;
        end else if (flush_e) begin
            idex_q <= '0;
        end else if (hold_e) begin
            idex_q <= idex_q;
        end else if (lu) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign valid_e      = idex_q.valid;
    assign reg_write_e  = idex_q.ctrl.reg_write;
    assign alu_src_e    = idex_q.ctrl.alu_src;
    assign mem_write_e  = idex_q.ctrl.mem_write;
    assign result_src_e = idex_q.ctrl.result_src;
    assign branch_e     = idex_q.ctrl.branch;
    assign alu_ctrl_e   = idex_q.ctrl.alu_ctrl;
    assign rd1_e        = idex_q.rd1;
    assign rd2_e        = idex_q.rd2;
    assign imm_e        = idex_q.imm;
    assign pc_e         = idex_q.pc;
    assign pc_plus4_e   = idex_q.pc_plus4;
    assign rs1_e        = idex_q.rs1;
    assign rs2_e        = idex_q.rs2;
    assign rd_e         = idex_q.rd;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Scoreboard bench for decode_stage_hz: directed hazard scenarios plus random
// traffic checked against a cycle-level reference model of the ID/EX slot.
module tb_decode_stage_hz;
    import riscv_pkg::*;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        alu_src;
        logic        mem_write;
        logic        result_src;
        logic        branch;
        logic [2:0]  alu_ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } e_t;

    typedef struct packed {
        logic       stall;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } id_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_d;
    logic [31:0] instr_d, pc_d, pc_plus4_d, result_w;
    logic        reg_write_w;
    logic [4:0]  rd_w;
    logic        flush_e, hold_e;
    logic        stall_d, valid_e, reg_write_e, alu_src_e, mem_write_e, result_src_e, branch_e;
    logic [2:0]  alu_ctrl_e;
    logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e;
    logic [4:0]  rs1_e, rs2_e, rd_e, rs1_d, rs2_d;

    always #5 clk = ~clk;

    decode_stage_hz dut (
        .clk(clk), .rst(rst), .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d),
        .pc_plus4_d(pc_plus4_d), .result_w(result_w), .reg_write_w(reg_write_w), .rd_w(rd_w),
        .flush_e(flush_e), .hold_e(hold_e), .stall_d(stall_d), .valid_e(valid_e),
        .reg_write_e(reg_write_e), .alu_src_e(alu_src_e), .mem_write_e(mem_write_e),
        .result_src_e(result_src_e), .branch_e(branch_e), .alu_ctrl_e(alu_ctrl_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .rs1_d(rs1_d), .rs2_d(rs2_d)
    );

    e_t          m_e;
    logic [31:0] m_rf [32];
    e_t          exp_e_q [$];
    id_t         exp_id_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        mon_en = 1'b0;
    logic        last_stall = 1'b0;
    logic [31:0] pc_cnt = 32'h1000;

    // ---------------- reference model ----------------
    function automatic logic [2:0] alu_ref(input logic [2:0] f3, input logic sub);
        case (f3)
            3'd0:    return sub ? ALU_SUB : ALU_ADD;
            3'd2:    return ALU_SLT;
            3'd4:    return ALU_XOR;
            3'd6:    return ALU_OR;
            3'd7:    return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic e_t decode_ref(input logic v, input logic [31:0] ins,
                                      input logic [31:0] pc, input logic [31:0] pc4,
                                      input logic [31:0] r1, input logic [31:0] r2);
        e_t e;
        logic [31:0] sx;
        e = '0;
        sx = {32{ins[31]}};
        e.valid = v; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        e.rd1 = r1; e.rd2 = r2; e.pc = pc; e.pc4 = pc4;
        case (ins[6:0])
            OP_LOAD: begin
                e.reg_write = 1; e.alu_src = 1; e.result_src = 1;
                e.imm = {sx[31:12], ins[31:20]};
            end
            OP_STORE: begin
                e.mem_write = 1; e.alu_src = 1;
                e.imm = {sx[31:12], ins[31:25], ins[11:7]};
            end
            OP_R: begin
                e.reg_write = 1; e.alu_ctrl = alu_ref(ins[14:12], ins[30]);
            end
            OP_I: begin
                e.reg_write = 1; e.alu_src = 1; e.alu_ctrl = alu_ref(ins[14:12], 1'b0);
                e.imm = {sx[31:12], ins[31:20]};
            end
            OP_BRANCH: begin
                e.branch = 1; e.alu_ctrl = ALU_SUB;
                e.imm = {sx[31:13], ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            OP_JAL: begin
                e.reg_write = 1;
                e.imm = {sx[31:21], ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                e.reg_write = 1; e.alu_src = 1;
                e.imm = ins & 32'hFFFF_F000;
            end
            default: ;
        endcase
        if (!v) begin
            e.reg_write = 0; e.alu_src = 0; e.mem_write = 0;
            e.result_src = 0; e.branch = 0; e.alu_ctrl = 3'd0;
        end
        return e;
    endfunction

    function automatic logic [31:0] rf_ref(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
        if (reg_write_w && rd_w == a) return result_w;
`endif
        return m_rf[a];
    endfunction

    function automatic logic lu_ref();
        logic [6:0] op;
        logic u1, u2;
        op = instr_d[6:0];
        u1 = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
        u2 = (op == OP_R || op == OP_STORE || op == OP_BRANCH);
        return m_e.valid && m_e.result_src && m_e.reg_write && m_e.rd != 5'd0 && valid_d &&
               ((m_e.rd == instr_d[19:15] && u1) || (m_e.rd == instr_d[24:20] && u2));
    endfunction

    // Called at posedge+1 with inputs already driven; advances one clock.
    task automatic cycle();
        e_t   nxt;
        logic lu;
        lu = lu_ref();
        last_stall = lu | hold_e;
        exp_id_q.push_back('{stall: last_stall, rs1: instr_d[19:15], rs2: instr_d[24:20]});
        if (!rst)         nxt = '0;
        else if (flush_e) nxt = '0;
        else if (hold_e)  nxt = m_e;
        else if (lu)      nxt = '0;
        else nxt = decode_ref(valid_d, instr_d, pc_d, pc_plus4_d,
                              rf_ref(instr_d[19:15]), rf_ref(instr_d[24:20]));
        @(posedge clk);
        m_e = nxt;
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        end else if (reg_write_w && rd_w != 5'd0) begin
            m_rf[rd_w] = result_w;
        end
        exp_e_q.push_back(m_e);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        e_t  got, x;
        id_t gid, xid;
        if (mon_en) begin
            got = '{valid: valid_e, reg_write: reg_write_e, alu_src: alu_src_e,
                    mem_write: mem_write_e, result_src: result_src_e, branch: branch_e,
                    alu_ctrl: alu_ctrl_e, rd1: rd1_e, rd2: rd2_e, imm: imm_e, pc: pc_e,
                    pc4: pc_plus4_e, rs1: rs1_e, rs2: rs2_e, rd: rd_e};
            if (exp_e_q.size() > 0) begin
                x = exp_e_q.pop_front();
                n_cmp++;
                if (got !== x) begin
                    n_bad++;
                    $display("FAIL idex_bundle t=%0t got v=%b ctl=%b%b%b%b%b alu=%0d rd1=%h rd2=%h imm=%h pc=%h rs=%0d/%0d rd=%0d | exp v=%b ctl=%b%b%b%b%b alu=%0d rd1=%h rd2=%h imm=%h pc=%h rs=%0d/%0d rd=%0d",
                             $time, got.valid, got.reg_write, got.alu_src, got.mem_write, got.result_src, got.branch,
                             got.alu_ctrl, got.rd1, got.rd2, got.imm, got.pc, got.rs1, got.rs2, got.rd,
                             x.valid, x.reg_write, x.alu_src, x.mem_write, x.result_src, x.branch,
                             x.alu_ctrl, x.rd1, x.rd2, x.imm, x.pc, x.rs1, x.rs2, x.rd);
                end
            end
            if (exp_id_q.size() > 0) begin
                xid = exp_id_q.pop_front();
                gid = '{stall: stall_d, rs1: rs1_d, rs2: rs2_d};
                n_cmp++;
                if (gid !== xid) begin
                    n_bad++;
                    $display("FAIL id_comb t=%0t got stall=%b rs1=%0d rs2=%0d exp stall=%b rs1=%0d rs2=%0d",
                             $time, gid.stall, gid.rs1, gid.rs2, xid.stall, xid.rs1, xid.rs2);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_id(input logic v, input logic [31:0] ins);
        valid_d = v; instr_d = ins; pc_d = pc_cnt; pc_plus4_d = pc_cnt + 32'd4;
        pc_cnt = pc_cnt + 32'd4;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] rd, input logic [31:0] val);
        reg_write_w = en; rd_w = rd; result_w = val;
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_R};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  ops [9];
        ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC, 7'b1111111};
        ins = $urandom;
        ins[6:0]   = ops[$urandom_range(0, 8)];
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        return ins;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b0; flush_e = 1'b0; hold_e = 1'b0;
        set_wb(1'b0, 5'd0, 32'd0);
        set_id(1'b1, enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd3));
        @(posedge clk); #1;
        m_e = '0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        exp_e_q.push_back(m_e);
        mon_en = 1'b1;
        cycle();                       // second reset cycle with valid_d=1
        rst = 1'b1;

        for (int i = 1; i < 8; i++) begin
            set_wb(1'b1, 5'(i), $urandom);
            set_id(1'b0, 32'd0);
            cycle();
        end
        set_wb(1'b0, 5'd0, 32'd0);

        // load-use: lw x5,0(x1); add x6,x5,x2 -> one stall, one bubble
        set_id(1'b1, enc_i(12'd0, 5'd1, 3'b010, 5'd5, OP_LOAD)); cycle();
        set_id(1'b1, enc_r(7'd0, 5'd2, 5'd5, 3'd0, 5'd6));       cycle();
        cycle();
        set_id(1'b0, 32'd0); cycle();

        // no false stall: lw x5 then lui x5; lw x0 then add x6,x0,x0
        set_id(1'b1, enc_i(12'd4, 5'd1, 3'b010, 5'd5, OP_LOAD)); cycle();
        set_id(1'b1, {20'h12345, 5'd5, OP_LUI});                 cycle();
        set_id(1'b1, enc_i(12'd8, 5'd1, 3'b010, 5'd0, OP_LOAD)); cycle();
        set_id(1'b1, enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd6));       cycle();

        // flush and hold together: flush wins
        set_id(1'b1, enc_i(12'd0, 5'd2, 3'b010, 5'd4, OP_LOAD)); cycle();
        set_id(1'b1, enc_r(7'd0, 5'd3, 5'd1, 3'd0, 5'd9));
        flush_e = 1'b1; hold_e = 1'b1; cycle();
        flush_e = 1'b0; hold_e = 1'b0; cycle();

        // hold for three cycles
        set_id(1'b1, enc_i(12'hF80, 5'd3, 3'd0, 5'd10, OP_I)); cycle();
        set_id(1'b1, enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd11));
        hold_e = 1'b1;
        repeat (3) cycle();
        hold_e = 1'b0; cycle();

        // WB-to-ID in the same cycle: add x8,x7,x7 while x7 <= DEADBEEF
        set_wb(1'b1, 5'd7, 32'hDEADBEEF);
        set_id(1'b1, enc_r(7'd0, 5'd7, 5'd7, 3'd0, 5'd8)); cycle();
        set_wb(1'b0, 5'd0, 32'd0);
        set_id(1'b1, enc_r(7'd0, 5'd7, 5'd7, 3'd0, 5'd8)); cycle();

        // random traffic; the bench acts as fetch and honours the predicted stall
        for (int n = 0; n < 600; n++) begin
            if (!last_stall) set_id($urandom_range(0, 7) != 0, rand_instr());
            set_wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
            hold_e  = ($urandom_range(0, 7) == 0);
            flush_e = ($urandom_range(0, 9) == 0);
            rst     = ($urandom_range(0, 79) != 0);
            cycle();
        end
        rst = 1'b1; hold_e = 1'b0; flush_e = 1'b0;
        set_wb(1'b0, 5'd0, 32'd0);
        set_id(1'b0, 32'd0);

        for (int i = 0; i < 10 && (exp_e_q.size() > 0 || exp_id_q.size() > 0); i++) @(negedge clk);
        #1;
        if (exp_e_q.size() > 0 || exp_id_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain got %0d pending entries, exp 0", exp_e_q.size() + exp_id_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
